// File: rtl/regfile_sb.sv
// Register file with clear sequencer and pending-write scoreboard; reg 0 reads zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              use1,
  input  logic              use2,
  input  logic              set_pend,
  input  logic [ADDR_W-1:0] A_pend,
  output logic              pend1,
  output logic              pend2,
  output logic              stall
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [NREGS-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0]   regs_q [NREGS];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                idle;
  logic                wr_ok;
  logic                byp1;
  logic                byp2;

  assign idle  = (state_q == ST_IDLE);
  assign wr_ok = idle && WE3 && (A3 != '0);

  // Next-state, scoreboard update and array write port selection
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_addr  = A3;
    mem_wdata = WD3;
    case (state_q)
      ST_IDLE: begin
        mem_we = wr_ok;
        if (clr) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          pend_d  = '0;
        end else begin
          if (wr_ok) pend_d[A3] = 1'b0;
          // a new producer on the same edge supersedes the retiring one
          if (set_pend && (A_pend != '0)) pend_d[A_pend] = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = '0;
        if (clr) begin
          idx_d = '0;
        end else if (idx_q == '1) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    pend_d[0] = 1'b0;
  end

  // Reset parks the sequencer at the start of a sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // Storage array is only zeroed by the sweep, never by reset
  always_ff @(posedge clk) begin
    if (mem_we) regs_q[mem_addr] <= mem_wdata;
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_ok && (A1 == A3);
  assign byp2 = wr_ok && (A2 == A3);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign RD1   = (!idle || (A1 == '0)) ? '0 : (byp1 ? WD3 : regs_q[A1]);
  assign RD2   = (!idle || (A2 == '0)) ? '0 : (byp2 ? WD3 : regs_q[A2]);
  assign pend1 = !byp1 && pend_q[A1];
  assign pend2 = !byp2 && pend_q[A2];
  assign busy  = !idle;
  assign stall = busy | (use1 & pend1) | (use2 & pend2);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// against a behavioural model of registers, pending bits and clear duration.
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          we3 = 1'b0;
  logic          use1 = 1'b0;
  logic          use2 = 1'b0;
  logic          set_pend = 1'b0;
  logic [AW-1:0] a3 = '0;
  logic [AW-1:0] a1 = '0;
  logic [AW-1:0] a2 = '0;
  logic [AW-1:0] a_pend = '0;
  logic [DW-1:0] wd3 = '0;
  logic          busy, stall, pend1, pend2;
  logic [DW-1:0] rd1, rd2;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_mem [NR];
  logic          m_pend [NR];
  int            m_remain;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .WE3(we3), .A3(a3), .WD3(wd3), .A1(a1), .A2(a2),
    .RD1(rd1), .RD2(rd2), .use1(use1), .use2(use2),
    .set_pend(set_pend), .A_pend(a_pend),
    .pend1(pend1), .pend2(pend2), .stall(stall)
  );

  always #5 clk = ~clk;

  // Observable effect of a clear: everything reads zero and stays busy for NR edges
  function automatic void model_clear_all();
    for (int i = 0; i < int'(NR); i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_remain = NR;
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_clear_all();
      return;
    end
    if (m_remain > 0) begin
      if (clr) m_remain = NR;
      else     m_remain = m_remain - 1;
    end else if (clr) begin
      model_clear_all();
    end else begin
      if (we3 && a3 != 0) begin
        m_mem[a3]  = wd3;
        m_pend[a3] = 1'b0;
      end
      if (set_pend && a_pend != 0) m_pend[a_pend] = 1'b1;
    end
  endfunction

  function automatic logic byp_hit(input logic [AW-1:0] a);
    return BYP && (m_remain == 0) && we3 && (a3 != 0) && (a == a3);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_remain > 0 || a == 0) return '0;
    if (byp_hit(a)) return wd3;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (m_remain > 0 || byp_hit(a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic exp_stall();
    return (m_remain > 0) || (use1 && exp_pend(a1)) || (use2 && exp_pend(a2));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear_all();
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(NR); i++) begin
      a1 = AW'(i);
      a2 = AW'(int'(NR) - 1 - i);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy edge=%0d got %b want 1", i, busy); end
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_stall edge=%0d got %b want 1", i, stall); end
      n_checks++; if (rd1 !== '0 || pend1 !== 1'b0) begin n_errors++; $display("FAIL reset_rd1 edge=%0d got %h/%b want 0/0", i, rd1, pend1); end
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy_end got %b want 0", busy); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall_end got %b want 0", stall); end
    for (int i = 0; i < int'(NR); i++) begin
      a1 = AW'(i);
      a2 = AW'(i);
      #1;
      n_checks++; if (rd1 !== '0 || rd2 !== '0) begin n_errors++; $display("FAIL reset_zero a=%0d got %h %h want 0", i, rd1, rd2); end
    end
  endtask

  task automatic test_write_read();
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0; a1 = 5'd5; a2 = 5'd5;
    #1;
    n_checks++; if (rd1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_rd1 got %h want deadbeef", rd1); end
    n_checks++; if (rd2 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_rd2 got %h want deadbeef", rd2); end
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h12345678;
    tick();
    we3 = 1'b0; a1 = 5'd0;
    #1;
    n_checks++; if (rd1 !== '0) begin n_errors++; $display("FAIL wr_r0 got %h want 0", rd1); end
  endtask

  task automatic test_scoreboard();
    set_pend = 1'b1; a_pend = 5'd7;
    tick();
    set_pend = 1'b0; a1 = 5'd7; use1 = 1'b1;
    #1;
    n_checks++; if (pend1 !== 1'b1) begin n_errors++; $display("FAIL sb_set_pend got %b want 1", pend1); end
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL sb_set_stall got %b want 1", stall); end
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h00000042;
    tick();
    we3 = 1'b0;
    #1;
    n_checks++; if (pend1 !== 1'b0) begin n_errors++; $display("FAIL sb_wb_pend got %b want 0", pend1); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL sb_wb_stall got %b want 0", stall); end
    n_checks++; if (rd1 !== 32'h00000042) begin n_errors++; $display("FAIL sb_wb_rd got %h want 00000042", rd1); end
    use1 = 1'b0;
    set_pend = 1'b1; a_pend = 5'd9; we3 = 1'b1; a3 = 5'd9; wd3 = 32'h99;
    tick();
    set_pend = 1'b0; we3 = 1'b0; a2 = 5'd9; use2 = 1'b1;
    #1;
    n_checks++; if (pend2 !== 1'b1) begin n_errors++; $display("FAIL sb_same_edge got %b want 1", pend2); end
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL sb_same_edge_stall got %b want 1", stall); end
    use2 = 1'b0;
  endtask

  task automatic test_bypass();
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h11111111;
    tick();
    we3 = 1'b0; set_pend = 1'b1; a_pend = 5'd3;
    tick();
    set_pend = 1'b0; we3 = 1'b1; a3 = 5'd3; wd3 = 32'hCAFEF00D; a1 = 5'd3;
    #1;
    n_checks++; if (rd1 !== (BYP ? 32'hCAFEF00D : 32'h11111111)) begin n_errors++; $display("FAIL byp_rd got %h want %h", rd1, BYP ? 32'hCAFEF00D : 32'h11111111); end
    n_checks++; if (pend1 !== !BYP) begin n_errors++; $display("FAIL byp_pend got %b want %b", pend1, !BYP); end
    tick();
    we3 = 1'b0;
    #1;
    n_checks++; if (rd1 !== 32'hCAFEF00D || pend1 !== 1'b0) begin n_errors++; $display("FAIL byp_after got %h/%b want cafef00d/0", rd1, pend1); end
  endtask

  task automatic test_clear();
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0; set_pend = 1'b1; a_pend = 5'd6;
    tick();
    set_pend = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      we3 = 1'b1; a3 = 5'd4; wd3 = 32'hAAAA5555; a1 = 5'd5;
      #1;
      n_checks++; if (busy !== 1'b1 || rd1 !== '0) begin n_errors++; $display("FAIL clr_sweep edge=%0d got %b/%h want 1/0", i, busy, rd1); end
      tick();
    end
    we3 = 1'b0; a1 = 5'd4; a2 = 5'd5;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL clr_done got %b want 0", busy); end
    n_checks++; if (rd1 !== '0 || rd2 !== '0) begin n_errors++; $display("FAIL clr_regs got %h %h want 0 0", rd1, rd2); end
    a1 = 5'd6;
    #1;
    n_checks++; if (pend1 !== 1'b0) begin n_errors++; $display("FAIL clr_pend got %b want 0", pend1); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL clr_restart edge=%0d got %b want 1", i, busy); end
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL clr_restart_end got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    set_pend = 1'b1; a_pend = 5'd8;
    tick();
    set_pend = 1'b0; a1 = 5'd8;
    #1;
    n_checks++; if (pend1 !== 1'b1) begin n_errors++; $display("FAIL arst_pre_pend got %b want 1", pend1); end
    #2;
    rst_n = 1'b0;
    model_clear_all();
    #1;
    n_checks++; if (busy !== 1'b1 || pend1 !== 1'b0 || stall !== 1'b1) begin n_errors++; $display("FAIL arst_idle got busy=%b pend=%b want 1 0", busy, pend1); end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    model_clear_all();
    #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL arst_mid got %b want 1", busy); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(NR); i++) begin
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL arst_sweep edge=%0d got %b want 1", i, busy); end
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL arst_sweep_end got %b want 0", busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 49) == 0);
      we3      = $urandom_range(0, 1) == 1;
      set_pend = $urandom_range(0, 2) == 0;
      use1     = $urandom_range(0, 1) == 1;
      use2     = $urandom_range(0, 1) == 1;
      a3       = AW'($urandom_range(0, 7));
      a_pend   = AW'($urandom_range(0, 7));
      a1       = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 7));
      a2       = AW'($urandom_range(0, 7));
      wd3      = DW'($urandom());
      #1;
      n_checks++; if (rd1 !== exp_rd(a1)) begin n_errors++; $display("FAIL rnd_rd1 cyc=%0d got %h want %h", i, rd1, exp_rd(a1)); end
      n_checks++; if (rd2 !== exp_rd(a2)) begin n_errors++; $display("FAIL rnd_rd2 cyc=%0d got %h want %h", i, rd2, exp_rd(a2)); end
      n_checks++; if (pend1 !== exp_pend(a1)) begin n_errors++; $display("FAIL rnd_pend1 cyc=%0d got %b want %b", i, pend1, exp_pend(a1)); end
      n_checks++; if (pend2 !== exp_pend(a2)) begin n_errors++; $display("FAIL rnd_pend2 cyc=%0d got %b want %b", i, pend2, exp_pend(a2)); end
      n_checks++; if (busy !== (m_remain > 0)) begin n_errors++; $display("FAIL rnd_busy cyc=%0d got %b want %b", i, busy, m_remain > 0); end
      n_checks++; if (stall !== exp_stall()) begin n_errors++; $display("FAIL rnd_stall cyc=%0d got %b want %b", i, stall, exp_stall()); end
      tick();
    end
    clr = 1'b0; we3 = 1'b0; set_pend = 1'b0; use1 = 1'b0; use2 = 1'b0;
  endtask

  initial begin
    model_clear_all();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
